pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller_pkg.sv | 31 +++
 rtl/pipeline_controller_if.sv | 50 +++++
 rtl/pipeline_controller_forward_unit.sv | 28 ++
 rtl/pipeline_controller.sv | 134 +++++++++++++
 tb/tb_pipeline_controller.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_controller_pkg.sv
// Shared pipeline-control types: operand forwarding select and controller states.
// Pure type/function package, no timing.
// No flow control of its own.
package pipeline_control_pkg;

   localparam int REG_ADDR_W = 5;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;

   // Operand source for the execute-stage operand muxes.
   typedef enum logic [1:0] {
      FWD_NONE = 2'd0,
      FWD_EX   = 2'd1,
      FWD_MEM  = 2'd2
   } forward_sel_e;

   typedef enum logic {
      RUN     = 1'b0,
      MC_WAIT = 1'b1
   } ctrl_state_e;

   // A producer hits a consumer when it writes a non-zero rd that the
   // consumer actually reads; x0 is hardwired and never forwarded.
   function automatic logic reg_hit(input logic      uses,
                                    input reg_addr_t rs,
                                    input logic      wr,
                                    input reg_addr_t rd);
      return uses && wr && (rd != '0) && (rd == rs);
   endfunction

endpackage

// File: rtl/pipeline_controller_if.sv
// Hazard-control bundle between the pipeline datapath and its controller.
// Wires only, no latency.
// No flow control; stall/flush outputs are the pipeline's backpressure.
interface pipeline_controller_if;
   import pipeline_control_pkg::*;

   reg_addr_t    id_rs1_i;
   reg_addr_t    id_rs2_i;
   logic         id_uses_rs1_i;
   logic         id_uses_rs2_i;
   reg_addr_t    ex_rd_i;
   logic         ex_reg_write_i;
   logic         ex_is_load_i;
   reg_addr_t    mem_rd_i;
   logic         mem_reg_write_i;
   logic         ex_jump_i;
   logic         ex_mc_start_i;
   logic         mc_done_i;

   logic         fetch_stall_o;
   logic         decode_stall_o;
   logic         execute_stall_o;
   logic         decode_flush_o;
   logic         execute_flush_o;
   forward_sel_e rs1_forward_o;
   forward_sel_e rs2_forward_o;
   logic [31:0]  stall_count_o;
   logic         mc_timeout_o;

   // Datapath side: supplies stage info, consumes control.
   modport master (
      output id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
             ex_rd_i, ex_reg_write_i, ex_is_load_i,
             mem_rd_i, mem_reg_write_i, ex_jump_i, ex_mc_start_i, mc_done_i,
      input  fetch_stall_o, decode_stall_o, execute_stall_o,
             decode_flush_o, execute_flush_o,
             rs1_forward_o, rs2_forward_o, stall_count_o, mc_timeout_o
   );

   // Controller side.
   modport slave (
      input  id_rs1_i, id_rs2_i, id_uses_rs1_i, id_uses_rs2_i,
             ex_rd_i, ex_reg_write_i, ex_is_load_i,
             mem_rd_i, mem_reg_write_i, ex_jump_i, ex_mc_start_i, mc_done_i,
      output fetch_stall_o, decode_stall_o, execute_stall_o,
             decode_flush_o, execute_flush_o,
             rs1_forward_o, rs2_forward_o, stall_count_o, mc_timeout_o
   );

endinterface

// File: rtl/pipeline_controller_forward_unit.sv
// Forwarding select for one decode-stage source operand.
// Purely combinational, zero latency.
// No flow control.
module forward_unit
   import pipeline_control_pkg::*;
(
   input  logic         id_uses_i,
   input  reg_addr_t    id_rs_i,
   input  reg_addr_t    ex_rd_i,
   input  logic         ex_reg_write_i,
   input  logic         ex_is_load_i,
   input  reg_addr_t    mem_rd_i,
   input  logic         mem_reg_write_i,
   output forward_sel_e fwd_sel_o
);

   // Youngest producer wins; a load in EX has no data yet, so it falls
   // through to the MEM check (the load-use stall covers that case).
   always_comb begin
      fwd_sel_o = FWD_NONE;
      if (reg_hit(id_uses_i, id_rs_i, ex_reg_write_i, ex_rd_i) && !ex_is_load_i) begin
         fwd_sel_o = FWD_EX;
      end else if (reg_hit(id_uses_i, id_rs_i, mem_reg_write_i, mem_rd_i)) begin
         fwd_sel_o = FWD_MEM;
      end
   end

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: forwarding, load-use stall, jump flush, multi-cycle wait.
// Stall/flush/forward are combinational (same cycle); counters update at the next edge.
// Holds fetch/decode/execute while a multi-cycle op runs, bounded by MC_TIMEOUT cycles.
module pipeline_controller
   import pipeline_control_pkg::*;
#(
   parameter int MC_TIMEOUT = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   pipeline_controller_if.slave  bus
);

   localparam int CNT_W = $clog2(MC_TIMEOUT + 1);

   ctrl_state_e      state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic [31:0]      stall_cnt_q, stall_cnt_d;

   logic fetch_stall, decode_stall, execute_stall;
   logic decode_flush, execute_flush;
   logic load_use;

   forward_unit u_fwd_rs1 (
      .id_uses_i       (bus.id_uses_rs1_i),
      .id_rs_i         (bus.id_rs1_i),
      .ex_rd_i         (bus.ex_rd_i),
      .ex_reg_write_i  (bus.ex_reg_write_i),
      .ex_is_load_i    (bus.ex_is_load_i),
      .mem_rd_i        (bus.mem_rd_i),
      .mem_reg_write_i (bus.mem_reg_write_i),
      .fwd_sel_o       (bus.rs1_forward_o)
   );

   forward_unit u_fwd_rs2 (
      .id_uses_i       (bus.id_uses_rs2_i),
      .id_rs_i         (bus.id_rs2_i),
      .ex_rd_i         (bus.ex_rd_i),
      .ex_reg_write_i  (bus.ex_reg_write_i),
      .ex_is_load_i    (bus.ex_is_load_i),
      .mem_rd_i        (bus.mem_rd_i),
      .mem_reg_write_i (bus.mem_reg_write_i),
      .fwd_sel_o       (bus.rs2_forward_o)
   );

   assign load_use = bus.ex_is_load_i &&
                     (reg_hit(bus.id_uses_rs1_i, bus.id_rs1_i, bus.ex_reg_write_i, bus.ex_rd_i) ||
                      reg_hit(bus.id_uses_rs2_i, bus.id_rs2_i, bus.ex_reg_write_i, bus.ex_rd_i));

   // Next state and stall/flush decode; jump beats multi-cycle start beats load-use.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      timeout_d     = timeout_q;
      fetch_stall   = 1'b0;
      decode_stall  = 1'b0;
      execute_stall = 1'b0;
      decode_flush  = 1'b0;
      execute_flush = 1'b0;
      unique case (state_q)
         RUN: begin
            if (bus.ex_jump_i) begin
               decode_flush  = 1'b1;
               execute_flush = 1'b1;
            end else if (bus.ex_mc_start_i) begin
               fetch_stall   = 1'b1;
               decode_stall  = 1'b1;
               execute_stall = 1'b1;
               wait_cnt_d    = '0;
               state_d       = MC_WAIT;
            end else if (load_use) begin
               fetch_stall   = 1'b1;
               decode_stall  = 1'b1;
               execute_flush = 1'b1;
            end
         end
         MC_WAIT: begin
            if (bus.mc_done_i) begin
               state_d = RUN;
            end else begin
               fetch_stall   = 1'b1;
               decode_stall  = 1'b1;
               execute_stall = 1'b1;
               wait_cnt_d    = wait_cnt_q + CNT_W'(1);
               if (wait_cnt_q == CNT_W'(MC_TIMEOUT - 1)) begin
                  timeout_d = 1'b1;
                  state_d   = RUN;
               end
            end
         end
         default: state_d = RUN;
      endcase
      if (rst_i) begin
         fetch_stall   = 1'b0;
         decode_stall  = 1'b0;
         execute_stall = 1'b0;
         decode_flush  = 1'b0;
         execute_flush = 1'b0;
      end
   end

   // Saturating count of decode-stall cycles.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (decode_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   // State, wait counter, sticky timeout and stall counter registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= RUN;
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.fetch_stall_o   = fetch_stall;
   assign bus.decode_stall_o  = decode_stall;
   assign bus.execute_stall_o = execute_stall;
   assign bus.decode_flush_o  = decode_flush;
   assign bus.execute_flush_o = execute_flush;
   assign bus.stall_count_o   = stall_cnt_q;
   assign bus.mc_timeout_o    = timeout_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller: directed scenarios then random traffic.
// Outputs sampled on the falling edge; reference model advances on the rising edge.
// Inputs change 1 time unit after the rising edge.
module tb_pipeline_controller;
   import pipeline_control_pkg::*;

   localparam int TO = 8;

   logic clk;
   logic rst;
   pipeline_controller_if bus ();

   pipeline_controller #(.MC_TIMEOUT(TO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: "are we waiting on a multi-cycle op", how long, plus counters.
   bit          m_waiting;
   int          m_waited;
   bit          m_timeout;
   int unsigned m_stalls;
   // Expected outputs for the current cycle.
   bit e_fs, e_ds, e_es, e_df, e_ef;
   int e_f1, e_f2;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int fwd_of(input int rs, input bit uses);
      if (uses && bus.ex_reg_write_i && bus.ex_rd_i != 0 && int'(bus.ex_rd_i) == rs && !bus.ex_is_load_i)
         return 1;
      if (uses && bus.mem_reg_write_i && bus.mem_rd_i != 0 && int'(bus.mem_rd_i) == rs)
         return 2;
      return 0;
   endfunction

   task automatic idle();
      bus.id_rs1_i = 0; bus.id_rs2_i = 0;
      bus.id_uses_rs1_i = 0; bus.id_uses_rs2_i = 0;
      bus.ex_rd_i = 0; bus.ex_reg_write_i = 0; bus.ex_is_load_i = 0;
      bus.mem_rd_i = 0; bus.mem_reg_write_i = 0;
      bus.ex_jump_i = 0; bus.ex_mc_start_i = 0; bus.mc_done_i = 0;
      rst = 0;
   endtask

   // Falling edge: derive expectations from the rules and compare everything.
   task automatic sample();
      bit lu;
      @(negedge clk);
      lu = bus.ex_is_load_i && bus.ex_reg_write_i && bus.ex_rd_i != 0 &&
           ((bus.id_uses_rs1_i && bus.id_rs1_i == bus.ex_rd_i) ||
            (bus.id_uses_rs2_i && bus.id_rs2_i == bus.ex_rd_i));
      e_fs = 0; e_ds = 0; e_es = 0; e_df = 0; e_ef = 0;
      if (!rst) begin
         if (m_waiting) begin
            if (!bus.mc_done_i) begin e_fs = 1; e_ds = 1; e_es = 1; end
         end else if (bus.ex_jump_i) begin
            e_df = 1; e_ef = 1;
         end else if (bus.ex_mc_start_i) begin
            e_fs = 1; e_ds = 1; e_es = 1;
         end else if (lu) begin
            e_fs = 1; e_ds = 1; e_ef = 1;
         end
      end
      e_f1 = fwd_of(int'(bus.id_rs1_i), bus.id_uses_rs1_i);
      e_f2 = fwd_of(int'(bus.id_rs2_i), bus.id_uses_rs2_i);
      check("fetch_stall",   32'(bus.fetch_stall_o),   32'(e_fs));
      check("decode_stall",  32'(bus.decode_stall_o),  32'(e_ds));
      check("execute_stall", 32'(bus.execute_stall_o), 32'(e_es));
      check("decode_flush",  32'(bus.decode_flush_o),  32'(e_df));
      check("execute_flush", 32'(bus.execute_flush_o), 32'(e_ef));
      check("rs1_forward",   32'(bus.rs1_forward_o),   32'(e_f1));
      check("rs2_forward",   32'(bus.rs2_forward_o),   32'(e_f2));
      check("stall_count",   bus.stall_count_o,        m_stalls);
      check("mc_timeout",    32'(bus.mc_timeout_o),    32'(m_timeout));
   endtask

   // Rising edge: advance the model with this cycle's inputs.
   task automatic advance();
      @(posedge clk);
      if (rst) begin
         m_waiting = 0; m_waited = 0; m_timeout = 0; m_stalls = 0;
      end else begin
         if (e_ds && m_stalls != 32'hFFFF_FFFF) m_stalls++;
         if (!m_waiting) begin
            if (bus.ex_mc_start_i && !bus.ex_jump_i) begin
               m_waiting = 1; m_waited = 0;
            end
         end else if (bus.mc_done_i) begin
            m_waiting = 0;
         end else begin
            m_waited++;
            if (m_waited == TO) begin
               m_timeout = 1; m_waiting = 0;
            end
         end
      end
      #1;
   endtask

   initial begin
      int base;
      idle();
      rst = 1;
      m_waiting = 0; m_waited = 0; m_timeout = 0; m_stalls = 0;

      // Reset with a jump and load-use presented: no stall or flush may leak out.
      bus.ex_jump_i = 1;
      bus.ex_is_load_i = 1; bus.ex_reg_write_i = 1; bus.ex_rd_i = 3;
      bus.id_rs1_i = 3; bus.id_uses_rs1_i = 1;
      sample();
      check("rst_decode_flush", 32'(bus.decode_flush_o), 32'd0);
      check("rst_fetch_stall",  32'(bus.fetch_stall_o),  32'd0);
      advance();
      sample();
      check("rst_stall_count", bus.stall_count_o, 32'd0);
      check("rst_timeout",     32'(bus.mc_timeout_o), 32'd0);
      advance();
      idle();

      // EX has priority over MEM; ex_rd=0 falls back to MEM.
      bus.id_rs1_i = 5; bus.id_uses_rs1_i = 1;
      bus.ex_rd_i = 5; bus.ex_reg_write_i = 1;
      bus.mem_rd_i = 5; bus.mem_reg_write_i = 1;
      sample();
      check("fwd_ex_priority", 32'(bus.rs1_forward_o), 32'(FWD_EX));
      advance();
      bus.ex_rd_i = 0;
      sample();
      check("fwd_mem_fallback", 32'(bus.rs1_forward_o), 32'(FWD_MEM));
      advance();
      idle();

      // Load-use on rs2, then the load reaches MEM.
      bus.ex_is_load_i = 1; bus.ex_reg_write_i = 1; bus.ex_rd_i = 7;
      bus.id_rs2_i = 7; bus.id_uses_rs2_i = 1;
      sample();
      check("lu_fetch_stall",  32'(bus.fetch_stall_o),   32'd1);
      check("lu_decode_stall", 32'(bus.decode_stall_o),  32'd1);
      check("lu_exec_flush",   32'(bus.execute_flush_o), 32'd1);
      advance();
      idle();
      bus.id_rs2_i = 7; bus.id_uses_rs2_i = 1;
      bus.mem_rd_i = 7; bus.mem_reg_write_i = 1;
      sample();
      check("lu_stall_count", bus.stall_count_o, 32'd1);
      check("lu_fwd_mem",     32'(bus.rs2_forward_o), 32'(FWD_MEM));
      check("lu_released",    32'(bus.decode_stall_o), 32'd0);
      advance();
      idle();

      // Jump overrides load-use.
      bus.ex_is_load_i = 1; bus.ex_reg_write_i = 1; bus.ex_rd_i = 9;
      bus.id_rs1_i = 9; bus.id_uses_rs1_i = 1; bus.ex_jump_i = 1;
      sample();
      check("jmp_decode_flush", 32'(bus.decode_flush_o),  32'd1);
      check("jmp_exec_flush",   32'(bus.execute_flush_o), 32'd1);
      check("jmp_no_stall",     32'(bus.fetch_stall_o),   32'd0);
      advance();
      idle();

      // Multi-cycle op finishing after 4 wait cycles.
      base = int'(bus.stall_count_o);
      bus.ex_mc_start_i = 1;
      sample();
      check("mc_start_stall", 32'(bus.execute_stall_o), 32'd1);
      advance();
      idle();
      for (int i = 0; i < 4; i++) begin
         sample();
         check("mc_wait_stall", 32'(bus.decode_stall_o), 32'd1);
         advance();
      end
      bus.mc_done_i = 1;
      sample();
      check("mc_done_release", 32'(bus.fetch_stall_o), 32'd0);
      advance();
      idle();
      bus.ex_jump_i = 1;
      sample();
      check("mc_stall_count", bus.stall_count_o, 32'(base + 5));
      check("mc_back_in_run", 32'(bus.decode_flush_o), 32'd1);
      advance();
      idle();

      // Timeout: no done for TO wait cycles.
      bus.ex_mc_start_i = 1;
      sample();
      advance();
      idle();
      for (int i = 0; i < TO; i++) begin
         sample();
         check("to_waiting_stall", 32'(bus.fetch_stall_o), 32'd1);
         check("to_not_yet",       32'(bus.mc_timeout_o),  32'd0);
         advance();
      end
      sample();
      check("to_set",      32'(bus.mc_timeout_o),  32'd1);
      check("to_released", 32'(bus.fetch_stall_o), 32'd0);
      advance();
      bus.ex_jump_i = 1;
      sample();
      check("to_run_flush", 32'(bus.decode_flush_o), 32'd1);
      check("to_sticky",    32'(bus.mc_timeout_o),   32'd1);
      advance();
      idle();

      // Reset in the middle of a multi-cycle wait.
      bus.ex_mc_start_i = 1;
      sample();
      advance();
      idle();
      sample();
      advance();
      sample();
      advance();
      rst = 1;
      sample();
      check("rst_mid_wait_stall", 32'(bus.decode_stall_o), 32'd0);
      advance();
      idle();
      bus.ex_jump_i = 1;
      sample();
      check("post_rst_stall",   32'(bus.fetch_stall_o),  32'd0);
      check("post_rst_run",     32'(bus.decode_flush_o), 32'd1);
      check("post_rst_count",   bus.stall_count_o,       32'd0);
      check("post_rst_timeout", 32'(bus.mc_timeout_o),   32'd0);
      advance();
      idle();

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         bus.id_rs1_i        = 5'($urandom_range(0, 3));
         bus.id_rs2_i        = 5'($urandom_range(0, 3));
         bus.id_uses_rs1_i   = 1'($urandom_range(0, 1));
         bus.id_uses_rs2_i   = 1'($urandom_range(0, 1));
         bus.ex_rd_i         = 5'($urandom_range(0, 3));
         bus.ex_reg_write_i  = 1'($urandom_range(0, 1));
         bus.ex_is_load_i    = ($urandom_range(0, 3) == 0);
         bus.mem_rd_i        = 5'($urandom_range(0, 3));
         bus.mem_reg_write_i = 1'($urandom_range(0, 1));
         bus.ex_jump_i       = ($urandom_range(0, 5) == 0);
         bus.ex_mc_start_i   = ($urandom_range(0, 6) == 0);
         bus.mc_done_i       = ($urandom_range(0, 4) == 0);
         rst                 = ($urandom_range(0, 59) == 0);
         sample();
         advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
